aes_128_inv_controller: RTL and testbench
=========================================

AES_128_INV_CONTROLLER -- requirements
Module: aes_128_inv_controller

Interface
REQ-001 Parameter NUM_ROUNDS, default 10: number of AES rounds.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 valid_in  in  1  ciphertext and key present on datapath inputs.
REQ-005 key_new_i  in  1  key differs from the cached schedule; sampled only on accept.
REQ-006 out_ready_i  in  1  consumer accepts plaintext.
REQ-007 ready_o  out  1  controller can accept a block.
REQ-008 state_load_o  out  1  datapath loads ciphertext into state register.
REQ-009 key_load_o  out  1  datapath loads cipher key into key register.
REQ-010 key_exp_en_o  out  1  forward key-expansion step enable.
REQ-011 add_key_en_o  out  1  initial AddRoundKey with round key NUM_ROUNDS.
REQ-012 inv_round_en_o  out  1  inverse round enable (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns).
REQ-013 inv_mix_bypass_o  out  1  skip InvMixColumns (final round).
REQ-014 key_dir_o  out  1  0 forward expansion, 1 inverse key schedule.
REQ-015 round_cnt_o  out  4  current round index.
REQ-016 valid_out  out  1  plaintext valid on datapath output.

Function
REQ-017 FSM states SHALL be IDLE, KEY_EXP, INIT, ROUND, FINAL, DONE.
REQ-018 ready_o SHALL be 1 in IDLE, and in DONE when out_ready_i=1; otherwise 0.
REQ-019 Accept = valid_in & ready_o; in the accept cycle, state_load_o=1 and key_load_o=1 (combinational).
REQ-020 On accept, if key_new_i=1 or key_cached=0, next state SHALL be KEY_EXP with round_cnt=1; otherwise INIT with round_cnt=NUM_ROUNDS.
REQ-021 KEY_EXP: key_exp_en_o=1, key_dir_o=0, round_cnt increments 1..NUM_ROUNDS; at NUM_ROUNDS, set key_cached=1 and go to INIT.
REQ-022 INIT (one cycle): add_key_en_o=1, key_dir_o=1, round_cnt_o=NUM_ROUNDS; next state ROUND with round_cnt=NUM_ROUNDS-1.
REQ-023 ROUND: inv_round_en_o=1, key_dir_o=1, round_cnt decrements per cycle; leave from round_cnt=1 to FINAL with round_cnt=0.
REQ-024 FINAL (one cycle): inv_round_en_o=1, inv_mix_bypass_o=1, round_cnt_o=0; next state DONE.
REQ-025 DONE: valid_out=1 and held until out_ready_i=1; then IDLE, or directly KEY_EXP/INIT if a new block is accepted in the same cycle.
REQ-026 Latency, accept cycle T: valid_out SHALL rise at T+12 with a cached key, and at T+22 with expansion (NUM_ROUNDS=10).
REQ-027 valid_in while ready_o=0 SHALL be ignored; no outputs change.
REQ-028 Every output not listed for a state SHALL be 0; round_cnt_o SHALL be 0 in IDLE and DONE.
REQ-029 round_cnt SHALL never leave 0..NUM_ROUNDS; the decrement below 0 SHALL be unreachable.

Reset
REQ-030 Asserting rst_ni low, at any time including mid-operation, SHALL force IDLE, round_cnt=0 and key_cached=0, with all outputs 0 except ready_o=1.
REQ-031 After reset, the first accepted block SHALL always take KEY_EXP, whatever the value of key_new_i.

Structure
REQ-032 Shared package aes_128_pkg SHALL hold the state enum, NUM_ROUNDS, and the round-counter width constant (4).
REQ-033 A sub-module aes_128_round_cnt (loadable up/down counter with terminal flags) SHALL be instantiated; the FSM SHALL stay in this module.

Verification
REQ-034 Reset, then accept with key_new_i=0 -> KEY_EXP 10 cycles (round_cnt 1..10), INIT, ROUND 9..1, FINAL, valid_out at T+22.
REQ-035 Second block, key_new_i=0, out_ready_i=1 -> no KEY_EXP; valid_out at T+12 for exactly 1 cycle.
REQ-036 out_ready_i held 0 for 5 cycles in DONE -> valid_out stays 1, ready_o=0, valid_in ignored.
REQ-037 DONE with out_ready_i=1 and valid_in=1 (cached key) -> same-cycle accept, state_load_o=1, next state INIT, no idle gap.
REQ-038 rst_ni low during ROUND (round_cnt=5) -> IDLE immediately, all outputs 0, next accept takes KEY_EXP.
REQ-039 key_new_i=1 with a cached key -> KEY_EXP re-executed, latency 22.

Source files
------------

// File: rtl/aes_128_pkg.sv
// aes_128_pkg: shared constants and FSM state type for the inverse AES-128 controller
package aes_128_pkg;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned CNT_W = 4;
  typedef enum logic [2:0] {IDLE, KEY_EXP, INIT, ROUND, FINAL, DONE} state_e;
endpackage

// File: rtl/aes_128_round_cnt.sv
// aes_128_round_cnt: loadable saturating up/down round counter with terminal flags
module aes_128_round_cnt import aes_128_pkg::*; #(
  parameter int unsigned MAX = NUM_ROUNDS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             up,
  input  logic             down,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max,
  output logic             at_one
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
  assign at_max = cnt == MAX_C;
  assign at_one = cnt == CNT_W'(1);
  // count saturates at both ends so it can never leave 0..MAX
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (up && !at_max) cnt <= cnt + 1'b1;
    else if (down && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/aes_128_inv_controller.sv
// aes_128_inv_controller: sequences key expansion and inverse rounds for AES-128 decryption
module aes_128_inv_controller #(
  parameter int unsigned NUM_ROUNDS = aes_128_pkg::NUM_ROUNDS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_in,
  input  logic                           key_new_i,
  input  logic                           out_ready_i,
  output logic                           ready_o,
  output logic                           state_load_o,
  output logic                           key_load_o,
  output logic                           key_exp_en_o,
  output logic                           add_key_en_o,
  output logic                           inv_round_en_o,
  output logic                           inv_mix_bypass_o,
  output logic                           key_dir_o,
  output logic [aes_128_pkg::CNT_W-1:0]  round_cnt_o,
  output logic                           valid_out
);
  import aes_128_pkg::*;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state, next;
  logic key_cached, accept, need_exp, cnt_load, at_max, at_one;
  logic [CNT_W-1:0] cnt, cnt_val;
  assign ready_o = state == IDLE || (state == DONE && out_ready_i);
  assign accept = valid_in && ready_o;
  assign need_exp = key_new_i || !key_cached;
  assign cnt_load = accept || state == INIT;
  assign cnt_val = accept ? (need_exp ? ONE : LAST) : LAST - 1'b1;
  aes_128_round_cnt #(.MAX(NUM_ROUNDS)) u_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .load(cnt_load), .load_val(cnt_val),
    .up(state == KEY_EXP), .down(state == ROUND),
    .cnt(cnt), .at_max(at_max), .at_one(at_one)
  );
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= next;
  // the expanded schedule stays valid until reset
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) key_cached <= 1'b0;
    else if (state == KEY_EXP && at_max) key_cached <= 1'b1;
  // next-state logic; DONE can chain straight into a new block
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = accept ? (need_exp ? KEY_EXP : INIT) : (state == DONE && out_ready_i) ? IDLE : state;
      KEY_EXP:    next = at_max ? INIT : KEY_EXP;
      INIT:       next = ROUND;
      ROUND:      next = at_one ? FINAL : ROUND;
      FINAL:      next = DONE;
      default:    next = IDLE;
    endcase
  end
  // datapath strobes decoded from state
  always_comb begin
    state_load_o = accept;
    key_load_o = accept;
    key_exp_en_o = state == KEY_EXP;
    add_key_en_o = state == INIT;
    inv_round_en_o = state == ROUND || state == FINAL;
    inv_mix_bypass_o = state == FINAL;
    key_dir_o = state == INIT || state == ROUND;
    round_cnt_o = (state == IDLE || state == DONE) ? '0 : cnt;
    valid_out = state == DONE;
  end
endmodule

// File: tb/tb_aes_128_inv_controller.sv
// tb_aes_128_inv_controller: directed checks of sequencing, latency, back-pressure and reset
module tb_aes_128_inv_controller;
  logic clk = 0, rst_ni = 0, valid_in = 0, key_new_i = 0, out_ready_i = 0;
  logic ready_o, state_load_o, key_load_o, key_exp_en_o, add_key_en_o;
  logic inv_round_en_o, inv_mix_bypass_o, key_dir_o, valid_out;
  logic [3:0] round_cnt_o;
  int checks = 0, errors = 0;

  aes_128_inv_controller dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_in(valid_in), .key_new_i(key_new_i),
    .out_ready_i(out_ready_i), .ready_o(ready_o), .state_load_o(state_load_o),
    .key_load_o(key_load_o), .key_exp_en_o(key_exp_en_o), .add_key_en_o(add_key_en_o),
    .inv_round_en_o(inv_round_en_o), .inv_mix_bypass_o(inv_mix_bypass_o),
    .key_dir_o(key_dir_o), .round_cnt_o(round_cnt_o), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic kn, input string tag);
    valid_in = 1;
    key_new_i = kn;
    #1;
    check({tag, " ready"}, ready_o, 1);
    check({tag, " state_load"}, state_load_o, 1);
    check({tag, " key_load"}, key_load_o, 1);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int lat = 0;
    int e = exp_lat - 12;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) valid_in = 0;
      #1;
      if (e != 0 && k == 1) begin
        check({tag, " kexp_en"}, key_exp_en_o, 1);
        check({tag, " kexp_cnt1"}, round_cnt_o, 1);
        check({tag, " kexp_dir"}, key_dir_o, 0);
      end
      if (e != 0 && k == e) check({tag, " kexp_cnt10"}, round_cnt_o, 10);
      if (k == e + 1) begin
        check({tag, " init_add"}, add_key_en_o, 1);
        check({tag, " init_cnt"}, round_cnt_o, 10);
        check({tag, " init_dir"}, key_dir_o, 1);
      end
      if (k == e + 2) begin
        check({tag, " round_en"}, inv_round_en_o, 1);
        check({tag, " round_cnt9"}, round_cnt_o, 9);
      end
      if (k == e + 10) check({tag, " round_cnt1"}, round_cnt_o, 1);
      if (k == e + 11) begin
        check({tag, " final_bypass"}, inv_mix_bypass_o, 1);
        check({tag, " final_cnt"}, round_cnt_o, 0);
        check({tag, " final_round_en"}, inv_round_en_o, 1);
      end
      if (valid_out) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " done_cnt"}, round_cnt_o, 0);
  endtask

  initial begin
    #1;
    check("rst ready", ready_o, 1);
    check("rst valid_out", valid_out, 0);
    check("rst cnt", round_cnt_o, 0);
    check("rst kexp", key_exp_en_o, 0);
    @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
    accept(0, "first");
    wait_done(22, "first");
    check("first ready_held", ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = 1;
      #1;
      check("hold valid_out", valid_out, 1);
      check("hold ready", ready_o, 0);
      check("hold state_load", state_load_o, 0);
    end
    valid_in = 0;
    out_ready_i = 1;
    #1;
    check("release ready", ready_o, 1);
    @(negedge clk);
    #1;
    check("idle valid_out", valid_out, 0);
    accept(0, "cached");
    wait_done(12, "cached");
    @(negedge clk);
    #1;
    check("cached one_cycle", valid_out, 0);
    out_ready_i = 0;
    accept(0, "pre_chain");
    wait_done(12, "pre_chain");
    out_ready_i = 1;
    accept(0, "chain");
    check("chain valid_out", valid_out, 1);
    wait_done(12, "chain");
    @(negedge clk);
    #1;
    accept(0, "midrst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_in = 0;
    end
    #1;
    check("midrst cnt5", round_cnt_o, 5);
    rst_ni = 0;
    #1;
    check("midrst ready", ready_o, 1);
    check("midrst round_en", inv_round_en_o, 0);
    check("midrst cnt", round_cnt_o, 0);
    check("midrst dir", key_dir_o, 0);
    check("midrst valid_out", valid_out, 0);
    @(negedge clk);
    rst_ni = 1;
    #1;
    accept(0, "postrst");
    wait_done(22, "postrst");
    @(negedge clk);
    #1;
    accept(1, "newkey");
    wait_done(22, "newkey");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
